// File: rtl/dec_n_seq_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
package dec_n_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int out_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/dec_n_seq_dec.sv
// Combinational n-to-2^n one-hot decoder.
module dec_n
    import dec_n_seq_pkg::*;
#(
    parameter int n = 5
) (
    input  logic [n-1:0]        src,
    output logic [out_w(n)-1:0] z
);

    for (genvar i = 0; i < out_w(n); i++) begin : g_bit
        assign z[i] = (src == n'(i));
    end

endmodule

// File: rtl/dec_n_seq.sv
// Registered one-hot decoder with valid/ready handshakes and a sweep mode
// that walks one line across [SWEEP_FIRST, SWEEP_LAST], then pulses done.
module dec_n_seq
    import dec_n_seq_pkg::*;
#(
    parameter int N           = 5,
    parameter int SWEEP_FIRST = 0,
    parameter int SWEEP_LAST  = (1 << N) - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        src,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sweep_req,
    output logic [out_w(N)-1:0] z,
    output logic                z_valid,
    input  logic                z_ready,
    output logic                sweep_busy,
    output logic                sweep_done
);

    localparam int            W         = out_w(N);
    localparam logic [N-1:0] FIRST_IDX = N'(SWEEP_FIRST);
    localparam logic [N-1:0] LAST_IDX  = N'(SWEEP_LAST);

    state_e         state, state_nxt;
    logic [N-1:0]   idx;
    logic [N-1:0]   dec_src;
    logic [W-1:0]   dec_z;
    logic           slot_free;
    logic           dec_load;
    logic           sweep_load;
    logic           drain_take;

    assign slot_free = !z_valid || z_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sweep_req) state_nxt = ST_SWEEP;
            ST_SWEEP: if (slot_free && idx == LAST_IDX) state_nxt = ST_DRAIN;
            ST_DRAIN: if (z_valid && z_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // sweep_req blocks in_ready so a colliding decode is never accepted.
    always_comb begin
        in_ready   = 1'b0;
        dec_load   = 1'b0;
        sweep_load = 1'b0;
        drain_take = 1'b0;
        sweep_busy = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                in_ready = !sweep_req && slot_free;
                dec_load = in_valid && in_ready;
            end
            ST_SWEEP: sweep_load = slot_free;
            ST_DRAIN: drain_take = z_valid && z_ready;
            default: ;
        endcase
    end

    // Index saturates at LAST_IDX; the DRAIN exit rewinds it for the next sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= FIRST_IDX;
        else if (state == ST_IDLE && sweep_req)
            idx <= FIRST_IDX;
        else if (sweep_load && idx != LAST_IDX)
            idx <= idx + 1'b1;
        else if (drain_take)
            idx <= FIRST_IDX;
    end

    assign dec_src = (state == ST_SWEEP) ? idx : src;

    dec_n #(.n(N)) u_dec (
        .src (dec_src),
        .z   (dec_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z          <= '0;
            z_valid    <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= drain_take;
            if (dec_load || sweep_load) begin
                z       <= dec_z;
                z_valid <= 1'b1;
            end else if (z_valid && z_ready) begin
                z       <= '0;
                z_valid <= 1'b0;
            end
        end
    end

endmodule
